// File: rtl/execute_lanes.sv
// execute_lanes: two fixed-latency ALU/MUL lanes plus one shared
// iterative divider, with speculative-tag flush of in-flight work.
`timescale 1ns/1ps

package execute_lanes_pkg;
    typedef logic bool;
    typedef logic [3:0] spectag_t;
    typedef logic [5:0] tag_t;

    typedef enum logic [1:0] {
        EX_NORMAL, EX_GEN_ADDR, EX_BRANCH, EX_JUMP
    } ex_mode_t;

    typedef enum logic [2:0] {
        ALU, LSU, BRU, CSR
    } unit_t;

    typedef struct packed {
        bool         is_valid;
        unit_t       Unit;
        ex_mode_t    mode;
        spectag_t    speculative_tag;
        logic [9:0]  Op;
        logic [31:0] Vj;
        logic [31:0] Vk;
        tag_t        tag;
    } ex_content_t;

    typedef struct packed {
        bool         is_valid;
        ex_mode_t    mode;
        tag_t        tag;
        logic [31:0] value;
    } cmp_t;

    typedef struct packed {
        logic        valid;
        logic        is_mul;
        logic        mul_hi;
        logic [32:0] ma;
        logic [32:0] mb;
        logic [31:0] value;
        tag_t        tag;
        ex_mode_t    mode;
        spectag_t    spectag;
    } lane_s1_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] value;
        tag_t        tag;
        ex_mode_t    mode;
        spectag_t    spectag;
    } lane_s2_t;
endpackage

module execute_lanes
    import execute_lanes_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  ex_content_t ex_contents [2],
    input  logic        flush_valid,
    input  spectag_t    flush_spectag,
    output cmp_t        results [3],
    output logic        div_busy
);
    typedef enum logic [1:0] {
        DV_IDLE, DV_SETUP, DV_ITER, DV_DONE
    } div_state_e;

    localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

    function automatic logic killed(
        input spectag_t st,
        input logic     fv,
        input spectag_t fs
    );
        return fv && ((st & fs) != '0);
    endfunction

    function automatic logic [31:0] alu(
        input logic        alt,
        input logic [2:0]  f3,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] r;
        case (f3)
            3'b000:  r = alt ? a - b : a + b;
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'b0, $signed(a) < $signed(b)};
            3'b011:  r = {31'b0, a < b};
            3'b100:  r = a ^ b;
            3'b101:  r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    lane_s1_t s1_q [2];
    lane_s1_t s1_d [2];
    lane_s2_t s2_q [2];
    lane_s2_t s2_d [2];
    cmp_t     lane_res [2];
    cmp_t     div_res;
    logic [1:0] div_req;

    always_comb begin : lane_decode
        ex_content_t cur;
        logic acc;
        logic gen;
        logic md;
        div_req = '0;
        for (int i = 0; i < 2; i++) begin
            cur = ex_contents[i];
            acc = cur.is_valid && cur.Unit == ALU &&
                  !killed(cur.speculative_tag, flush_valid, flush_spectag);
            gen = cur.mode == EX_GEN_ADDR;
            md  = !gen && cur.Op[9:3] == 7'b0000001;
            div_req[i] = acc && md && cur.Op[2];
            s1_d[i] = '0;
            s1_d[i].valid   = acc && !div_req[i];
            s1_d[i].is_mul  = md && !cur.Op[2];
            s1_d[i].mul_hi  = cur.Op[1:0] != 2'b00;
            // MULHU zero-extends both, MULHSU only the multiplier
            s1_d[i].ma      = {~&cur.Op[1:0] & cur.Vj[31], cur.Vj};
            s1_d[i].mb      = {~cur.Op[1] & cur.Vk[31], cur.Vk};
            s1_d[i].value   = gen ? cur.Vj + cur.Vk
                                  : alu(cur.Op[8], cur.Op[2:0], cur.Vj, cur.Vk);
            s1_d[i].tag     = cur.tag;
            s1_d[i].mode    = cur.mode;
            s1_d[i].spectag = cur.speculative_tag;
        end
    end

    always_comb begin : lane_stage2
        logic [63:0] pa;
        logic [63:0] pb;
        logic [63:0] prod;
        for (int i = 0; i < 2; i++) begin
            pa   = {{31{s1_q[i].ma[32]}}, s1_q[i].ma};
            pb   = {{31{s1_q[i].mb[32]}}, s1_q[i].mb};
            prod = pa * pb;
            s2_d[i].valid   = s1_q[i].valid &&
                              !killed(s1_q[i].spectag, flush_valid, flush_spectag);
            s2_d[i].value   = !s1_q[i].is_mul ? s1_q[i].value
                            : s1_q[i].mul_hi  ? prod[63:32] : prod[31:0];
            s2_d[i].tag     = s1_q[i].tag;
            s2_d[i].mode    = s1_q[i].mode;
            s2_d[i].spectag = s1_q[i].spectag;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                s1_q[i] <= '0;
                s2_q[i] <= '0;
            end else begin
                s1_q[i] <= s1_d[i];
                s2_q[i] <= s2_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lane_res[i].is_valid = s2_q[i].valid &&
                !killed(s2_q[i].spectag, flush_valid, flush_spectag);
            lane_res[i].mode  = s2_q[i].mode;
            lane_res[i].tag   = s2_q[i].tag;
            lane_res[i].value = s2_q[i].value;
        end
    end

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] dv_a_q, dv_a_d;
    logic [31:0] dv_b_q, dv_b_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dsr_q, dsr_d;
    logic [1:0]  dv_op_q, dv_op_d;
    tag_t        dv_tag_q, dv_tag_d;
    ex_mode_t    dv_mode_q, dv_mode_d;
    spectag_t    dv_spec_q, dv_spec_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        dz_q, dz_d;
    logic        dv_kill;
    logic        dv_take;
    logic        dv_sel;
    logic [32:0] dv_sh;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign dv_kill = killed(dv_spec_q, flush_valid, flush_spectag);
    // lane 0 wins a same-cycle divide collision
    assign dv_take = state_q == DV_IDLE && |div_req;
    assign dv_sel  = !div_req[0];

    always_ff @(posedge clk) begin
        if (reset) state_q <= DV_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DV_IDLE:  if (dv_take) state_d = DV_SETUP;
            DV_SETUP: state_d = DV_ITER;
            DV_ITER:  if (cnt_q == LAST_ITER) state_d = DV_DONE;
            default:  state_d = DV_IDLE;
        endcase
        if (state_q != DV_IDLE && dv_kill) state_d = DV_IDLE;
    end

    always_comb begin : div_path
        logic a_neg;
        logic b_neg;
        cnt_d     = cnt_q;
        dv_a_d    = dv_a_q;
        dv_b_d    = dv_b_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dsr_d     = dsr_q;
        dv_op_d   = dv_op_q;
        dv_tag_d  = dv_tag_q;
        dv_mode_d = dv_mode_q;
        dv_spec_d = dv_spec_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        dz_d      = dz_q;
        a_neg     = !dv_op_q[0] && dv_a_q[31];
        b_neg     = !dv_op_q[0] && dv_b_q[31];
        dv_sh     = {rem_q, quot_q[31]};
        unique case (state_q)
            DV_IDLE: if (dv_take) begin
                dv_a_d    = ex_contents[dv_sel].Vj;
                dv_b_d    = ex_contents[dv_sel].Vk;
                dv_op_d   = ex_contents[dv_sel].Op[1:0];
                dv_tag_d  = ex_contents[dv_sel].tag;
                dv_mode_d = ex_contents[dv_sel].mode;
                dv_spec_d = ex_contents[dv_sel].speculative_tag;
                cnt_d     = '0;
            end
            DV_SETUP: begin
                quot_d  = a_neg ? -dv_a_q : dv_a_q;
                dsr_d   = b_neg ? -dv_b_q : dv_b_q;
                rem_d   = '0;
                q_neg_d = a_neg ^ b_neg;
                r_neg_d = a_neg;
                dz_d    = dv_b_q == '0;
            end
            DV_ITER: begin
                if (dv_sh >= {1'b0, dsr_q}) begin
                    rem_d  = 32'(dv_sh - {1'b0, dsr_q});
                    quot_d = {quot_q[30:0], 1'b1};
                end else begin
                    rem_d  = dv_sh[31:0];
                    quot_d = {quot_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
        dv_a_q    <= dv_a_d;
        dv_b_q    <= dv_b_d;
        quot_q    <= quot_d;
        rem_q     <= rem_d;
        dsr_q     <= dsr_d;
        dv_op_q   <= dv_op_d;
        dv_tag_q  <= dv_tag_d;
        dv_mode_q <= dv_mode_d;
        dv_spec_q <= dv_spec_d;
        q_neg_q   <= q_neg_d;
        r_neg_q   <= r_neg_d;
        dz_q      <= dz_d;
    end

    always_comb begin
        q_fix = dz_q ? '1 : (q_neg_q ? -quot_q : quot_q);
        r_fix = dz_q ? dv_a_q : (r_neg_q ? -rem_q : rem_q);
        div_res.is_valid = state_q == DV_DONE && !dv_kill;
        div_res.mode     = dv_mode_q;
        div_res.tag      = dv_tag_q;
        div_res.value    = dv_op_q[1] ? r_fix : q_fix;
        div_busy         = state_q != DV_IDLE;
    end

    always_comb begin
        results[0] = lane_res[0];
        results[1] = lane_res[1];
        results[2] = div_res;
    end
endmodule

// File: tb/tb_execute_lanes.sv
// Directed self-checking bench for execute_lanes: lanes, multiply,
// divider corner cases, flush squash and mid-operation reset.
`timescale 1ns/1ps

module tb_execute_lanes;
    import execute_lanes_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    ex_content_t ex_in [2];
    logic        flush_valid;
    spectag_t    flush_spectag;
    cmp_t        res [3];
    logic        div_busy;

    int checks = 0;
    int failures = 0;

    localparam logic [9:0] OP_ADD   = 10'b0000000_000;
    localparam logic [9:0] OP_SUB   = 10'b0100000_000;
    localparam logic [9:0] OP_SRA   = 10'b0100000_101;
    localparam logic [9:0] OP_MUL   = 10'b0000001_000;
    localparam logic [9:0] OP_MULH  = 10'b0000001_001;
    localparam logic [9:0] OP_MULHU = 10'b0000001_011;
    localparam logic [9:0] OP_DIV   = 10'b0000001_100;
    localparam logic [9:0] OP_DIVU  = 10'b0000001_101;
    localparam logic [9:0] OP_REM   = 10'b0000001_110;
    localparam logic [9:0] OP_REMU  = 10'b0000001_111;

    localparam logic [9:0] DV_OP [6] = '{
        OP_DIV, OP_REM, OP_DIVU, OP_DIV, OP_REMU, OP_REM
    };
    localparam logic [31:0] DV_A [6] = '{
        32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h0000_1234,
        32'h8000_0000, 32'd100, 32'hFFFF_FFF9
    };
    localparam logic [31:0] DV_B [6] = '{
        32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd7, 32'd0
    };
    localparam logic [31:0] DV_EXP [6] = '{
        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'h8000_0000, 32'd2, 32'hFFFF_FFF9
    };

    execute_lanes #(.DIV_ITERS(32)) dut (
        .clk(clk),
        .reset(reset),
        .ex_contents(ex_in),
        .flush_valid(flush_valid),
        .flush_spectag(flush_spectag),
        .results(res),
        .div_busy(div_busy)
    );

    always #5 clk = ~clk;

    function automatic ex_content_t mk(
        input unit_t       u,
        input ex_mode_t    m,
        input spectag_t    s,
        input logic [9:0]  op,
        input logic [31:0] vj,
        input logic [31:0] vk,
        input tag_t        tg
    );
        ex_content_t r;
        r.is_valid        = 1'b1;
        r.Unit            = u;
        r.mode            = m;
        r.speculative_tag = s;
        r.Op              = op;
        r.Vj              = vj;
        r.Vk              = vk;
        r.tag             = tg;
        return r;
    endfunction

    function automatic logic is_div_op(input ex_content_t e);
        return e.is_valid && e.Unit == ALU && e.mode != EX_GEN_ADDR &&
               e.Op[9:2] == 8'b0000001_1;
    endfunction

    task automatic clear_in();
        ex_in[0]      = '0;
        ex_in[1]      = '0;
        flush_valid   = 1'b0;
        flush_spectag = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // protocol monitor: divide-class issue collisions and busy violations
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (is_div_op(ex_in[0]) && is_div_op(ex_in[1])) begin
                failures++;
                $display("FAIL div_dual_issue got=2 divs required=<=1");
            end
            if ((is_div_op(ex_in[0]) || is_div_op(ex_in[1])) && div_busy) begin
                failures++;
                $display("FAIL div_issue_busy got busy=1 required=0");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b1;
        clear_in();
        repeat (3) next_cycle();
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (res[i].is_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_valid[%0d] got=%b required=0", i, res[i].is_valid);
            end
        end
        checks++;
        if (div_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b required=0", div_busy);
        end
        next_cycle();
    endtask

    task automatic test_add_sub();
        logic ev;
        for (int c = 0; c < 5; c++) begin
            if (c == 0) ex_in[0] = mk(ALU, EX_NORMAL, 4'b0, OP_ADD, 32'd5, 32'd7, 6'd3);
            if (c == 1) ex_in[0] = mk(ALU, EX_NORMAL, 4'b0, OP_SUB, 32'd5, 32'd7, 6'd4);
            if (c == 2) clear_in();
            @(negedge clk);
            ev = (c == 2 || c == 3);
            checks++;
            if (res[0].is_valid !== ev) begin
                failures++;
                $display("FAIL addsub_valid c=%0d got=%b required=%b", c, res[0].is_valid, ev);
            end
            checks++;
            if (res[1].is_valid !== 1'b0) begin
                failures++;
                $display("FAIL addsub_lane1 c=%0d got=%b required=0", c, res[1].is_valid);
            end
            if (c == 2) begin
                checks++;
                if (res[0].value !== 32'd12 || res[0].tag !== 6'd3 ||
                    res[0].mode !== EX_NORMAL) begin
                    failures++;
                    $display("FAIL add_result got=%h/%0d/%0d required=0000000c/3/0",
                             res[0].value, res[0].tag, res[0].mode);
                end
            end
            if (c == 3) begin
                checks++;
                if (res[0].value !== 32'hFFFF_FFFE || res[0].tag !== 6'd4) begin
                    failures++;
                    $display("FAIL sub_result got=%h/%0d required=fffffffe/4",
                             res[0].value, res[0].tag);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_genaddr_sra();
        ex_in[0] = mk(ALU, EX_NORMAL, 4'b0, OP_SRA, 32'h8000_0000, 32'd4, 6'd6);
        ex_in[1] = mk(ALU, EX_GEN_ADDR, 4'b0, OP_ADD, 32'h1000, 32'h24, 6'd5);
        next_cycle();
        clear_in();
        @(negedge clk);
        checks++;
        if (res[0].is_valid !== 1'b0 || res[1].is_valid !== 1'b0) begin
            failures++;
            $display("FAIL ga_early got=%b%b required=00", res[0].is_valid, res[1].is_valid);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (res[1].is_valid !== 1'b1 || res[1].value !== 32'h1024 ||
            res[1].mode !== EX_GEN_ADDR || res[1].tag !== 6'd5) begin
            failures++;
            $display("FAIL genaddr got=%b/%h/%0d/%0d required=1/00001024/1/5",
                     res[1].is_valid, res[1].value, res[1].mode, res[1].tag);
        end
        checks++;
        if (res[0].is_valid !== 1'b1 || res[0].value !== 32'hF800_0000) begin
            failures++;
            $display("FAIL sra got=%b/%h required=1/f8000000",
                     res[0].is_valid, res[0].value);
        end
        next_cycle();
    endtask

    task automatic test_mul();
        ex_in[0] = mk(ALU, EX_NORMAL, 4'b0, OP_MULH, 32'h8000_0000, 32'd2, 6'd10);
        ex_in[1] = mk(ALU, EX_NORMAL, 4'b0, OP_MULHU, 32'h8000_0000, 32'd2, 6'd11);
        next_cycle();
        ex_in[0] = mk(ALU, EX_NORMAL, 4'b0, OP_MUL, 32'h8000_0000, 32'd2, 6'd12);
        ex_in[1] = mk(LSU, EX_NORMAL, 4'b0, OP_ADD, 32'd1, 32'd1, 6'd13);
        next_cycle();
        clear_in();
        @(negedge clk);
        checks++;
        if (res[0].is_valid !== 1'b1 || res[0].value !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL mulh got=%b/%h required=1/ffffffff", res[0].is_valid, res[0].value);
        end
        checks++;
        if (res[1].is_valid !== 1'b1 || res[1].value !== 32'h0000_0001) begin
            failures++;
            $display("FAIL mulhu got=%b/%h required=1/00000001", res[1].is_valid, res[1].value);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (res[0].is_valid !== 1'b1 || res[0].value !== 32'h0 || res[0].tag !== 6'd12) begin
            failures++;
            $display("FAIL mul got=%b/%h/%0d required=1/00000000/12",
                     res[0].is_valid, res[0].value, res[0].tag);
        end
        checks++;
        if (res[1].is_valid !== 1'b0) begin
            failures++;
            $display("FAIL non_alu_ignored got=%b required=0", res[1].is_valid);
        end
        next_cycle();
    endtask

    // each vector issues exactly in the first cycle after the prior DONE
    task automatic test_back_to_back_div();
        logic eb;
        logic ev;
        for (int v = 0; v < 6; v++) begin
            ex_in[0] = mk(ALU, EX_NORMAL, 4'b0, DV_OP[v], DV_A[v], DV_B[v], 6'(20 + v));
            for (int c = 0; c < 35; c++) begin
                if (c == 1) clear_in();
                @(negedge clk);
                eb = (c >= 1);
                ev = (c == 34);
                checks++;
                if (div_busy !== eb) begin
                    failures++;
                    $display("FAIL div_busy v=%0d c=%0d got=%b required=%b", v, c, div_busy, eb);
                end
                checks++;
                if (res[2].is_valid !== ev) begin
                    failures++;
                    $display("FAIL div_valid v=%0d c=%0d got=%b required=%b",
                             v, c, res[2].is_valid, ev);
                end
                if (c == 2) begin
                    checks++;
                    if (res[0].is_valid !== 1'b0) begin
                        failures++;
                        $display("FAIL div_no_lane v=%0d got=%b required=0", v, res[0].is_valid);
                    end
                end
                if (c == 34) begin
                    checks++;
                    if (res[2].value !== DV_EXP[v] || res[2].tag !== 6'(20 + v)) begin
                        failures++;
                        $display("FAIL div_value v=%0d got=%h/%0d required=%h/%0d",
                                 v, res[2].value, res[2].tag, DV_EXP[v], 20 + v);
                    end
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_flush();
        clear_in();
        for (int c = 0; c < 37; c++) begin
            if (c == 0) ex_in[0] = mk(ALU, EX_NORMAL, 4'b0010, OP_DIV, 32'd100, 32'd3, 6'd30);
            if (c == 1) clear_in();
            if (c == 8) ex_in[0] = mk(ALU, EX_NORMAL, 4'b0010, OP_ADD, 32'd1, 32'd1, 6'd31);
            if (c == 9) begin
                ex_in[0] = mk(ALU, EX_NORMAL, 4'b0010, OP_ADD, 32'd1, 32'd1, 6'd32);
                ex_in[1] = mk(ALU, EX_NORMAL, 4'b0100, OP_ADD, 32'd1, 32'd2, 6'd33);
            end
            if (c == 10) begin
                ex_in[0]      = mk(ALU, EX_NORMAL, 4'b0011, OP_ADD, 32'd1, 32'd1, 6'd34);
                ex_in[1]      = '0;
                flush_valid   = 1'b1;
                flush_spectag = 4'b0010;
            end
            if (c == 11) clear_in();
            @(negedge clk);
            if (c == 10) begin
                checks++;
                if (div_busy !== 1'b1) begin
                    failures++;
                    $display("FAIL flush_busy_f got=%b required=1", div_busy);
                end
            end
            if (c >= 10 && c <= 12) begin
                checks++;
                if (res[0].is_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL flush_lane0 c=%0d got=%b required=0", c, res[0].is_valid);
                end
            end
            if (c == 11) begin
                checks++;
                if (div_busy !== 1'b0) begin
                    failures++;
                    $display("FAIL flush_busy_f1 got=%b required=0", div_busy);
                end
                checks++;
                if (res[1].is_valid !== 1'b1 || res[1].value !== 32'd3 ||
                    res[1].tag !== 6'd33) begin
                    failures++;
                    $display("FAIL flush_survivor got=%b/%h/%0d required=1/00000003/33",
                             res[1].is_valid, res[1].value, res[1].tag);
                end
            end
            if (c >= 10) begin
                checks++;
                if (res[2].is_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL flush_div_result c=%0d got=%b required=0", c, res[2].is_valid);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        clear_in();
        for (int c = 0; c < 42; c++) begin
            if (c == 0) ex_in[0] = mk(ALU, EX_NORMAL, 4'b0, OP_DIV, 32'd50, 32'd5, 6'd40);
            if (c == 1) clear_in();
            if (c == 3) begin
                ex_in[0] = mk(ALU, EX_NORMAL, 4'b0, OP_ADD, 32'd2, 32'd3, 6'd41);
                ex_in[1] = mk(ALU, EX_NORMAL, 4'b0, OP_ADD, 32'd2, 32'd3, 6'd42);
            end
            if (c == 4) begin
                ex_in[0] = mk(ALU, EX_NORMAL, 4'b0, OP_ADD, 32'd4, 32'd4, 6'd43);
                ex_in[1] = mk(ALU, EX_NORMAL, 4'b0, OP_ADD, 32'd4, 32'd4, 6'd44);
            end
            if (c == 5) begin
                clear_in();
                reset = 1'b1;
            end
            if (c == 6) begin
                reset = 1'b0;
                ex_in[0] = mk(ALU, EX_NORMAL, 4'b0, OP_DIV, 32'd100, 32'hFFFF_FFFD, 6'd45);
            end
            if (c == 7) clear_in();
            @(negedge clk);
            if (c == 5) begin
                checks++;
                if (res[0].is_valid !== 1'b1 || res[0].value !== 32'd5 || div_busy !== 1'b1) begin
                    failures++;
                    $display("FAIL pre_reset got=%b/%h/%b required=1/00000005/1",
                             res[0].is_valid, res[0].value, div_busy);
                end
            end
            if (c == 6) begin
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (res[i].is_valid !== 1'b0) begin
                        failures++;
                        $display("FAIL midreset_valid[%0d] got=%b required=0", i, res[i].is_valid);
                    end
                end
                checks++;
                if (div_busy !== 1'b0) begin
                    failures++;
                    $display("FAIL midreset_busy got=%b required=0", div_busy);
                end
            end
            if (c == 7 || c == 39 || c == 40 || c == 41) begin
                checks++;
                if (div_busy !== (c != 41)) begin
                    failures++;
                    $display("FAIL post_reset_busy c=%0d got=%b required=%b", c, div_busy, c != 41);
                end
            end
            if (c == 34 || c == 39 || c == 41) begin
                checks++;
                if (res[2].is_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL post_reset_div_idle c=%0d got=%b required=0", c, res[2].is_valid);
                end
            end
            if (c == 40) begin
                checks++;
                if (res[2].is_valid !== 1'b1 || res[2].value !== 32'hFFFF_FFDF ||
                    res[2].tag !== 6'd45) begin
                    failures++;
                    $display("FAIL post_reset_div got=%b/%h/%0d required=1/ffffffdf/45",
                             res[2].is_valid, res[2].value, res[2].tag);
                end
            end
            next_cycle();
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_in();
        test_reset();
        test_add_sub();
        test_genaddr_sra();
        test_mul();
        test_back_to_back_div();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/execute_lanes.md
# execute_lanes

Consumer end of the wakeup/select interface in the r2rv out-of-order core. Each cycle it accepts up to two `ex_content_t` bundles, executes ALU-unit work, and broadcasts tagged results back to the reorder/reservation buffer. That work is RV32I integer ops, address generation and the RV32M multiply/divide ops. It provides two fixed-latency pipelined lanes plus one shared iterative divider, and squashes in-flight work on a speculative-tag flush.

## Interface
- `DIV_ITERS`, default 32, number of radix-2 divider iterations; fixed to the operand width.
- `clk`  in  1  the only clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ex_contents[2]`  in  `ex_content_t`  issued ops from wakeup.
  - Fields used: `is_valid`, `Unit`, `mode`, `speculative_tag`, `Op`, `Vj`, `Vk`, `tag`.
  - `Op` is `{funct7, funct3}`.
- `flush_valid`  in  1  branch misprediction flush strobe.
- `flush_spectag`  in  `spectag_t`  mask of squashed speculation levels.
- `results[3]`  out  `cmp_t` (`{bool is_valid; ex_mode_t mode; tag_t tag; logic [31:0] value}`).
  - Index 0 is lane 0, index 1 is lane 1, index 2 is the divider.
- `div_busy`  out  1  divider occupied; wakeup must not issue a divide-class op while it is high.

## Operation
- **Accepted inputs.** An input is accepted when `is_valid && Unit == ALU` and it is not squashed. Other units are ignored and produce no result.
- **Classes**, decided in this priority order:
  - `mode == EX_GEN_ADDR`: value = `Vj + Vk` (Vk carries A). Result `mode` = `EX_GEN_ADDR`.
  - `Op[9:3] == 7'b0000001` and `Op[2] == 1`: divide class (DIV, DIVU, REM, REMU by `Op[1:0]`).
  - `Op[9:3] == 7'b0000001` and `Op[2] == 0`: multiply class (MUL, MULH, MULHSU, MULHU by `Op[1:0]`).
  - Otherwise: RV32I ALU by `funct3`.
    - `Op[8]` selects SUB over ADD and SRA over SRL.
    - Shift amount is `Vk[4:0]`.
    - SLT is signed; SLTU is unsigned.
- **Multiply.** Operands are sign- or zero-extended to 33 bits per op. Stage 1 registers the operands; stage 2 forms the 66-bit product and takes bits [31:0] (MUL) or [63:32] (MULH*).
- **Lane pipeline.** Each lane is two registered stages. ALU and address-generation results go through a delay register, so every lane op has the same latency as a multiply. This means the lanes never have an output conflict.
- **Divider FSM** (shared).
  - States: IDLE → SETUP → ITER (`DIV_ITERS` cycles, 5-bit counter) → DONE → IDLE.
  - SETUP latches tag and spectag, takes absolute values for signed ops, and records the quotient and remainder signs.
  - ITER performs restoring shift-subtract.
  - DONE applies sign fix-up and drives `results[2]` for one cycle.
  - Divide by zero: quotient = `32'hFFFFFFFF`, remainder = dividend.
  - Signed overflow (`0x80000000 / -1`): quotient = `0x80000000`, remainder = 0.
- **Divide-class issue rules.**
  - If both lanes present a divide-class op in the same cycle, lane 0 is taken and lane 1 is dropped. This is a protocol violation; the bench must flag it.
  - A divide-class op issued while `div_busy` is high is dropped. This is also a violation.
  - Divide ops produce no lane result.
- **Flush.**
  - An op is squashed when `flush_valid && (speculative_tag & flush_spectag) != 0`.
  - This applies to incoming ops in the same cycle, to every lane stage register, and to the divider in any non-IDLE state. A squashed divider returns to IDLE on the next edge.
  - Results on `results[*]` in the flush cycle are suppressed combinationally.
- **Pass-through.** `tag` and `mode` pass through unchanged.
- **Reset.** Clears all stage valids, sets the divider FSM to IDLE and the counter to 0. Reset takes effect mid-operation and discards all in-flight work.

## Timing
- Reset values: `results[*].is_valid` = 0 and `div_busy` = 0 from the first cycle after reset. Data fields are don't-care while invalid.
- Ops are sampled at the edge ending cycle t.
- Lane latency is 2: the result is valid during cycle t+2. Each lane is fully pipelined, with one new op per cycle per lane.
- Divider, accepted at edge t:
  - SETUP in t+1.
  - ITER in t+2..t+33.
  - DONE in t+34, when `results[2]` is valid.
  - `div_busy` is high t+1..t+34 inclusive (registered from FSM state ≠ IDLE).
  - The next divide-class op may be issued in cycle t+35.
- Flush in cycle f:
  - No result from a squashed op appears in cycle f or later.
  - `div_busy` falls at f+1 if the divider was squashed.
- Results from all three ports may be valid in the same cycle; the consumer accepts all three (no back-pressure).

## Test plan
- Lane 0 ADD `Vj=5, Vk=7, tag=3` at cycle 0 → `results[0]` valid only in cycle 2, value 12, tag 3, `EX_NORMAL`. Back-to-back SUB at cycle 1 `Vj=5, Vk=7` → cycle 3 value `0xFFFFFFFE`.
- Lane 1 `EX_GEN_ADDR` `Vj=0x1000, Vk=0x24` plus lane 0 SRA `Vj=0x80000000, Vk=4` in the same cycle → both at t+2: `0x1024` (`EX_GEN_ADDR`) and `0xF8000000`.
- `0x80000000 * 2`:
  - MULH → `0xFFFFFFFF`.
  - MULHU → `0x00000001`.
  - MUL → `0x00000000`.
  - All arrive at t+2.
- Divider, each op issued at cycle 0:
  - DIV `-7/2` → `-3` at cycle 34, with `div_busy` high cycles 1..34.
  - REM → `-1`.
  - DIVU `x/0` → `0xFFFFFFFF`.
  - DIV `0x80000000/-1` → `0x80000000`.
- Flush: divider op `spectag=0b0010` plus lane op `spectag=0b0100` in flight, `flush_spectag=0b0010` at cycle 10 → no divider result, `div_busy`=0 at cycle 11, lane result still delivered.
- Reset asserted at cycle 5 during a divide and with both lanes full → all `is_valid`=0 and `div_busy`=0 from cycle 6. A new DIV issued at cycle 6 completes at cycle 40.
